// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode map, FSM state encoding and width-independent
//               constants for the multi-cycle ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_SLL  = 4'b0000;
    localparam logic [OPW-1:0] OP_SRA  = 4'b0001;
    localparam logic [OPW-1:0] OP_SRL  = 4'b0010;
    localparam logic [OPW-1:0] OP_MUL  = 4'b0011;
    localparam logic [OPW-1:0] OP_DIV  = 4'b0100;
    localparam logic [OPW-1:0] OP_ADD  = 4'b0101;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0110;
    localparam logic [OPW-1:0] OP_AND  = 4'b0111;
    localparam logic [OPW-1:0] OP_OR   = 4'b1000;
    localparam logic [OPW-1:0] OP_XOR  = 4'b1001;
    localparam logic [OPW-1:0] OP_NOR  = 4'b1010;
    localparam logic [OPW-1:0] OP_SLT  = 4'b1011;
    localparam logic [OPW-1:0] OP_SLTU = 4'b1100;
    localparam logic [OPW-1:0] OP_MULS = 4'b1101;
    localparam logic [OPW-1:0] OP_DIVS = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative radix-2 shift-add multiplier / restoring divider.
//               One bit per clock; operates on magnitudes and applies the
//               sign fix-up combinationally on the final step so the result
//               is ready to be registered in the same edge as 'last'.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_op;
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_dtrial;
    logic               w_dok;
    logic [WIDTH:0]     w_nhi;
    logic [WIDTH-1:0]   w_nlo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_amag   = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_bmag   = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: add multiplicand when multiplier LSB is set, then shift right
    assign w_msum   = r_hi + (r_lo[0] ? {1'b0, r_op} : '0);
    // Divide step: shift next dividend bit into remainder and trial-subtract
    assign w_dshift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_dtrial = w_dshift - {1'b0, r_op};
    assign w_dok    = ~w_dtrial[WIDTH];

    // Next-step accumulator values for whichever operation is running
    always_comb begin
        w_nhi = {1'b0, w_msum[WIDTH:1]};
        w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            w_nhi = w_dok ? {1'b0, w_dtrial[WIDTH-1:0]} : {1'b0, w_dshift[WIDTH-1:0]};
            w_nlo = {r_lo[WIDTH-2:0], w_dok};
        end
    end

    assign w_prod     = {w_nhi[WIDTH-1:0], w_nlo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo      = r_neg_q ? -w_nlo : w_nlo;
    assign w_rem      = r_neg_r ? -w_nhi[WIDTH-1:0] : w_nhi[WIDTH-1:0];

    assign lo   = r_div ? w_quo : w_prod_fix[WIDTH-1:0];
    assign hi   = r_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
    assign last = (r_cnt == CW'(1));

    // Operand capture on load, then one iteration per clock until the counter drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (load) begin
            r_hi    <= '0;
            r_lo    <= is_div ? w_amag : w_bmag;
            r_op    <= is_div ? w_bmag : w_amag;
            r_cnt   <= CW'(WIDTH);
            r_div   <= is_div;
            r_neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= is_signed & a[WIDTH-1];
        end else if (r_cnt != '0) begin
            r_hi    <= w_nhi;
            r_lo    <= w_nlo;
            r_cnt   <= r_cnt - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : EX-stage ALU with single-cycle simple ops and an iterative
//               multiply/divide engine behind a start/ready/done handshake.
//               Optional macro ALU_MULDIV_SIGNED_EN enables opcodes 1101
//               (signed multiply) and 1110 (signed divide).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       AluOP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] R2,
    output logic             equal,
    output logic             div_zero
);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_mul_op;
    logic             w_div_op;
    logic             w_sgn;
    logic             w_divz;
    logic [WIDTH-1:0] w_simple;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_last;

`ifdef ALU_MULDIV_SIGNED_EN
    assign w_mul_op = (AluOP == OP_MUL) || (AluOP == OP_MULS);
    assign w_div_op = (AluOP == OP_DIV) || (AluOP == OP_DIVS);
    assign w_sgn    = (AluOP == OP_MULS) || (AluOP == OP_DIVS);
`else
    assign w_mul_op = (AluOP == OP_MUL);
    assign w_div_op = (AluOP == OP_DIV);
    assign w_sgn    = 1'b0;
`endif

    assign w_divz = w_div_op && (B == '0);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .is_div    (w_div_op),
        .is_signed (w_sgn),
        .a         (A),
        .b         (B),
        .lo        (w_lo),
        .hi        (w_hi),
        .last      (w_last)
    );

    // Single-cycle result mux; unassigned codes fall through to A+B
    always_comb begin
        w_simple = A + B;
        case (AluOP)
            OP_SLL:  w_simple = B << shamt;
            OP_SRA:  w_simple = $unsigned($signed(B) >>> shamt);
            OP_SRL:  w_simple = B >> shamt;
            OP_SUB:  w_simple = A - B;
            OP_AND:  w_simple = A & B;
            OP_OR:   w_simple = A | B;
            OP_XOR:  w_simple = A ^ B;
            OP_NOR:  w_simple = ~(A | B);
            OP_SLT: begin
                w_simple    = '0;
                w_simple[0] = ($signed(A) < $signed(B));
            end
            OP_SLTU: begin
                w_simple    = '0;
                w_simple[0] = (A < B);
            end
            default: w_simple = A + B;
        endcase
    end

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and engine load strobe; start is only honoured in IDLE
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_divz) begin
                        w_next = ST_DONE;
                    end else if (w_mul_op) begin
                        w_load = 1'b1;
                        w_next = ST_MUL;
                    end else if (w_div_op) begin
                        w_load = 1'b1;
                        w_next = ST_DIV;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Result and flag registers; values hold until the next completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R        <= '0;
            R2       <= '0;
            equal    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                equal <= (A == B);
                if (w_divz) begin
                    R        <= '1;
                    R2       <= A;
                    div_zero <= 1'b1;
                end else if (!w_mul_op && !w_div_op) begin
                    R        <= w_simple;
                    R2       <= '0;
                    div_zero <= 1'b0;
                end
            end else if ((r_state == ST_MUL || r_state == ST_DIV) && w_last) begin
                R        <= w_lo;
                R2       <= w_hi;
                div_zero <= 1'b0;
            end
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_MUL) || (r_state == ST_DIV);
    assign done  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_multicycle
// Description : Scoreboard bench for alu_multicycle: directed cases plus
//               randomized traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     AluOP;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [SHW-1:0] shamt;
    logic           ready;
    logic           busy;
    logic           done;
    logic [W-1:0]   R;
    logic [W-1:0]   R2;
    logic           equal;
    logic           div_zero;

    alu_multicycle #(
        .WIDTH(W),
        .SHW  (SHW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .AluOP    (AluOP),
        .A        (A),
        .B        (B),
        .shamt    (shamt),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .R        (R),
        .R2       (R2),
        .equal    (equal),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] r2;
        logic         eq;
        logic         dz;
        int unsigned  lat;
        int unsigned  exp_cyc;
        string        name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference model: results straight from the opcode definitions using wide arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [SHW-1:0] sh);
        exp_t            e;
        longint unsigned pu;
        longint          ps;
        longint          qa;
        longint          qb;
        longint          qq;
        longint          qr;
        e.r  = a + b;
        e.r2 = '0;
        e.eq = (a == b);
        e.dz = 1'b0;
        e.lat = 1;
        e.exp_cyc = 0;
        e.name = "";
        case (op)
            4'd0:  e.r = b << sh;
            4'd1:  e.r = $signed(b) >>> sh;
            4'd2:  e.r = b >> sh;
            4'd3: begin
                pu = 64'(a) * 64'(b);
                e.r = pu[31:0]; e.r2 = pu[63:32]; e.lat = W + 1;
            end
            4'd4: begin
                if (b == 0) begin
                    e.r = '1; e.r2 = a; e.dz = 1'b1;
                end else begin
                    e.r = a / b; e.r2 = a % b; e.lat = W + 1;
                end
            end
            4'd5:  e.r = a + b;
            4'd6:  e.r = a - b;
            4'd7:  e.r = a & b;
            4'd8:  e.r = a | b;
            4'd9:  e.r = a ^ b;
            4'd10: e.r = ~(a | b);
            4'd11: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: e.r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_SIGNED_EN
            4'd13: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                e.r = ps[31:0]; e.r2 = ps[63:32]; e.lat = W + 1;
            end
            4'd14: begin
                if (b == 0) begin
                    e.r = '1; e.r2 = a; e.dz = 1'b1;
                end else begin
                    qa = longint'($signed(a));
                    qb = longint'($signed(b));
                    qq = qa / qb;
                    qr = qa % qb;
                    e.r = qq[31:0]; e.r2 = qr[31:0]; e.lat = W + 1;
                end
            end
`endif
            default: e.r = a + b;
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_R"},   R,        mon_e.r);
                chk({mon_e.name, "_R2"},  R2,       mon_e.r2);
                chk({mon_e.name, "_eq"},  equal,    mon_e.eq);
                chk({mon_e.name, "_dz"},  div_zero, mon_e.dz);
                chk({mon_e.name, "_lat"}, cyc,      mon_e.exp_cyc);
            end
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [SHW-1:0] sh);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout actual=0 required=1", nm);
            return;
        end
        e = model(op, a, b, sh);
        e.name = nm;
        e.exp_cyc = cyc + e.lat;
        sbq.push_back(e);
        AluOP = op; A = a; B = b; shamt = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (e.lat > 1) begin
            chk({nm, "_busy"},  busy,  1'b1);
            chk({nm, "_ready"}, ready, 1'b0);
        end
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            A = 32'($urandom); B = 32'($urandom);
            AluOP = 4'($urandom); shamt = SHW'($urandom);
            start = (!ready && $urandom_range(0, 3) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout actual=0 required=1", nm);
            sbq.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; AluOP = '0; A = '0; B = '0; shamt = '0;
        repeat (3) @(negedge clk);
        chk("rst_R", R, 0);
        chk("rst_R2", R2, 0);
        chk("rst_eq", equal, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        rst = 1'b0;

        issue("add", 4'b0101, 32'd5, 32'd7, 5'd0);
        issue("mul", 4'b0011, 32'hFFFF_FFFF, 32'd2, 5'd0);
        issue("div", 4'b0100, 32'd100, 32'd7, 5'd0);
        issue("div0", 4'b0100, 32'd9, 32'd0, 5'd0);
        issue("sra", 4'b0001, 32'd0, 32'h8000_0000, 5'd4);
        issue("sltu", 4'b1100, 32'd1, 32'hFFFF_FFFF, 5'd0);
        issue("slt", 4'b1011, 32'd1, 32'hFFFF_FFFF, 5'd0);
        issue("op13", 4'b1101, 32'd3, 32'd4, 5'd0);
        issue("muls", 4'b1101, 32'hFFFF_FFFD, 32'd5, 5'd0);
        issue("divs", 4'b1110, 32'hFFFF_FFF9, 32'd2, 5'd0);
        issue("divs_min", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        issue("divs0", 4'b1110, 32'd9, 32'd0, 5'd0);
        issue("eq", 4'b0110, 32'd42, 32'd42, 5'd0);

        for (int i = 0; i < 150; i++) begin
            issue("rnd", 4'($urandom), rnd_opnd(), rnd_opnd(), SHW'($urandom));
        end

        // Reset in the middle of a multiply: nothing may complete
        @(negedge clk);
        AluOP = 4'b0011; A = 32'd1234; B = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        AluOP = 4'b0101; A = 32'd1; B = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_R", R, 0);
        chk("midrst_R2", R2, 0);
        chk("midrst_eq", equal, 0);
        chk("midrst_dz", div_zero, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", ready, 1);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue("add_after_rst", 4'b0101, 32'd1, 32'd1, 5'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
